memory_responder: RTL

- Single-port word-organised memory that services load, store and instruction-fetch requests issued by the multicycle control unit.
- Sits on the memory side of the request interface and applies RV32I byte/half/word lane selection on stores and sign/zero extension on loads.
- Returns data, or an error flag, through a valid/ready response handshake after a programmable latency.

---
 rtl/memory_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//   Single-port, word-organised data/instruction memory on the memory side of
//   the multicycle core's request interface. Applies RV32I byte/half/word lane
//   selection on stores and sign/zero extension on loads. Each response comes
//   back through a valid/ready handshake a fixed LATENCY cycles after the
//   request is accepted. At most one request is outstanding.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   LATENCY     : cycles from request acceptance to rsp_valid (1..15)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   req_valid  : request present
//   req_ready  : responder can accept a request
//   req_write  : 1 = store, 0 = load/fetch
//   req_funct3 : RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr   : byte address (never masked; out-of-range is an error)
//   req_wdata  : store data, low byte/half/word used
//   rsp_valid  : response present
//   rsp_ready  : requester accepts response
//   rsp_rdata  : extended load data, 0 for stores and errors
//   rsp_error  : misaligned, out-of-range or illegal-funct3 request
// -----------------------------------------------------------------------------
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Control state (asynchronously reset)
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Captured request (data path, no reset)
  logic        write_q, write_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic          mem_we;
  logic          req_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [AW-1:0] widx;
  logic [31:0]   rword;

  // Error classification of a captured request.
  function automatic logic check_err(input logic        wr,
                                     input logic [2:0]  f3,
                                     input logic [31:0] a);
    logic misaligned;
    logic out_of_range;
    logic illegal;
    misaligned   = ((f3[1:0] == 2'b01) && a[0]) ||
                   ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    out_of_range = ({1'b0, a} >= ADDR_LIMIT);
    illegal      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                   (wr && f3[2]);
    return misaligned || out_of_range || illegal;
  endfunction

  // Select the addressed byte/half of a word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign widx    = addr_q[AW+1:2];
  assign rword   = mem[widx];
  assign req_err = check_err(write_q, f3_q, addr_q);

  // Store lane enables and replicated store data.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  // Output decode. A response being consumed frees the slot in the same
  // cycle, so the next request can be taken on the handshake edge; req_ready
  // never looks at req_valid.
  always_comb begin
    req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    rsp_valid = (state_q == S_RESP);
    accept    = req_ready && req_valid;
    access    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    mem_we    = access && write_q && !req_err;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept) begin
      write_d = req_write;
      f3_d    = req_funct3;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = CNT_INIT;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          err_d   = req_err;
          rdata_d = (req_err || write_q) ? 32'd0
                                         : extend_load(f3_q, addr_q[1:0], rword);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = accept ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request registers
  always_ff @(posedge clk) begin
    write_q <= write_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Memory array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

endmodule
